lvds_frame_tx: RTL
==================

// Module: lvds_frame_tx
// PURPOSE
//  Transmit-side frame formatter for the 12-bit SDR pixel link. Takes pixels over a
//  valid/ready stream and emits one 12-bit word per SDR_CLK: sync codes, pixels, blanking.
//  Used as the sensor/link emulator feeding the word-alignment receiver, and for self-test.
// PARAMETERS
//  LINE_PIXELS  4     pixels per line, 1..1024
//  FRAME_LINES  2     lines per frame, 1..1024
//  H_BLANK      2     idle words after EOL, 0..255
//  V_BLANK      3     idle words after EOF, 0..255
//  IDLE_WORD    12'h000  word driven in idle/blanking
//  UFLOW_WORD   12'h000  word substituted for a missing pixel
// PORTS
//  SDR_CLK      in   1   word clock, rising edge
//  RST_n        in   1   asynchronous, active-low reset
//  Frame_start  in   1   single-cycle request to send one frame
//  Pix_data     in   12  pixel word
//  Pix_valid    in   1   Pix_data valid
//  Pix_ready    out  1   pixel accepted this cycle when Pix_valid&Pix_ready
//  TX_data      out  12  registered link word
//  Frame_busy   out  1   high from accepted start until last V_BLANK word sent
//  Line_count   out  10  index of line in progress (0-based)
//  Pixel_count  out  10  index of next pixel in current line
//  Underflow    out  1   sticky: a pixel slot had Pix_valid low
// BEHAVIOUR
//  Reset (async): TX_data=IDLE_WORD, Pix_ready=0, Frame_busy=0, counts=0,
//   Underflow=0, state IDLE, pending start cleared; mid-frame reset aborts immediately.
//  Sync codes (48 bit): SOF FFF000000_9D0, SOL FFF000000_800, EOL FFF000000_AB0,
//   EOF FFF000000_B60. Sent low word first: [11:0],[23:12],[35:24],[47:36]
//   (e.g. SOL = 800,000,000,FFF on consecutive cycles).
//  FSM: IDLE -> SYNC_S -> PIXEL -> SYNC_E -> HBLANK -> SYNC_S ... ;
//   last line: SYNC_E(EOF) -> VBLANK -> IDLE.
//   IDLE: TX_data=IDLE_WORD; Frame_start (or pending) -> SYNC_S next cycle, Frame_busy=1,
//     Underflow cleared at start acceptance.
//   SYNC_S: 4 words; SOF when Line_count==0 else SOL.
//   PIXEL: exactly LINE_PIXELS cycles; Pix_ready=1 (decoded from state register, no
//     combinational path from Pix_valid). Valid -> TX_data<=Pix_data; not valid ->
//     TX_data<=UFLOW_WORD, Underflow<=1; slot still counted (line length never varies).
//   SYNC_E: 4 words; EOF when Line_count==FRAME_LINES-1 else EOL.
//   HBLANK/VBLANK: H_BLANK/V_BLANK idle words; zero length skips the state.
//  Latency: pixel accepted at edge k appears on TX_data after edge k; first pixel
//   word directly follows the FFF of SOF/SOL, no gap.
//  Counters: 2-bit sync word index; Pixel_count 0..LINE_PIXELS-1, reset to 0 at each
//   SYNC_S; Line_count increments in HBLANK entry, 0 in IDLE; blank counter 8 bit.
//  Frame_start while Frame_busy: latched into one pending flag (further pulses lost);
//   pending frame starts the cycle after VBLANK ends (back-to-back frames).
//  Frame_start same cycle as final VBLANK word: treated as pending, no lost cycle.
//  Pix_valid outside PIXEL ignored; Pix_ready=0 there. Pixel values sent raw.
// STRUCTURE
//  Include file lvds_sync_defs.vh: SOF/SOL/EOL/EOF constants, state encodings;
//   shared with the receiver side.
//  No sub-module: sync word select is a local function of code and word index.
// TESTING
//  Params 4/2/2/3, Frame_start pulse, Pix_valid=1, data 0x101.. -> 9D0,000,000,FFF,
//   101,102,103,104, AB0,000,000,FFF, 000,000, 800,000,000,FFF, 105..108,
//   B60,000,000,FFF, 000x3, then Frame_busy=0.
//  Pix_valid low on 3rd pixel of line 0 -> TX word 000 in that slot, Underflow=1,
//   line still 4 pixels; next Frame_start clears Underflow.
//  Frame_start pulsed mid-frame twice -> exactly one extra frame, SOF follows last
//   VBLANK word on next cycle.
//  H_BLANK=0, V_BLANK=0 -> SOL immediately after EOL's FFF; IDLE right after EOF.
//  RST_n low during PIXEL -> TX_data=000, Pix_ready=0, Frame_busy=0 without a clock;
//   after release, no output until new Frame_start.
//  FRAME_LINES=1 -> SOF ... EOF only, no SOL/EOL emitted.

Source files
------------

// File: rtl/lvds_frame_tx_pkg.sv
// Shared link definitions: sync codes, FSM encoding, sync word selection.
// The receiver side imports the same package so both ends agree on the codes.
package lvds_frame_tx_pkg;

  localparam int unsigned WORD_W = 12;

  // 48-bit sync sequences, transmitted low word first.
  localparam logic [47:0] SYNC_SOF = 48'hFFF0000009D0;
  localparam logic [47:0] SYNC_SOL = 48'hFFF000000800;
  localparam logic [47:0] SYNC_EOL = 48'hFFF000000AB0;
  localparam logic [47:0] SYNC_EOF = 48'hFFF000000B60;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC_S = 3'd1,
    ST_PIXEL  = 3'd2,
    ST_SYNC_E = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VBLANK = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CODE_SOF = 2'd0,
    CODE_SOL = 2'd1,
    CODE_EOL = 2'd2,
    CODE_EOF = 2'd3
  } sync_code_e;

  // Word idx (0 = first on the wire) of the selected 48-bit sync sequence.
  function automatic logic [WORD_W-1:0] sync_word(input sync_code_e code,
                                                  input logic [1:0]  idx);
    logic [47:0] seq;
    case (code)
      CODE_SOF: seq = SYNC_SOF;
      CODE_SOL: seq = SYNC_SOL;
      CODE_EOL: seq = SYNC_EOL;
      default:  seq = SYNC_EOF;
    endcase
    case (idx)
      2'd0:    sync_word = seq[11:0];
      2'd1:    sync_word = seq[23:12];
      2'd2:    sync_word = seq[35:24];
      default: sync_word = seq[47:36];
    endcase
  endfunction

endpackage

// File: rtl/lvds_frame_tx.sv
// Transmit frame formatter for the 12-bit SDR pixel link: emits SOF/SOL,
// pixel slots, EOL/EOF and blanking, one registered word per SDR_CLK.
module lvds_frame_tx
  import lvds_frame_tx_pkg::*;
#(
  parameter int          LINE_PIXELS = 4,
  parameter int          FRAME_LINES = 2,
  parameter int          H_BLANK     = 2,
  parameter int          V_BLANK     = 3,
  parameter logic [11:0] IDLE_WORD   = 12'h000,
  parameter logic [11:0] UFLOW_WORD  = 12'h000
) (
  input  logic        SDR_CLK,
  input  logic        RST_n,
  input  logic        Frame_start,
  input  logic [11:0] Pix_data,
  input  logic        Pix_valid,
  output logic        Pix_ready,
  output logic [11:0] TX_data,
  output logic        Frame_busy,
  output logic [9:0]  Line_count,
  output logic [9:0]  Pixel_count,
  output logic        Underflow
);

  localparam logic [9:0] LAST_PIX  = 10'(LINE_PIXELS - 1);
  localparam logic [9:0] LAST_LINE = 10'(FRAME_LINES - 1);
  localparam logic [7:0] H_LAST    = 8'(H_BLANK - 1);
  localparam logic [7:0] V_LAST    = 8'(V_BLANK - 1);

  state_e      state_q, state_d;
  logic [1:0]  widx_q, widx_d;
  logic [9:0]  pix_q, pix_d;
  logic [9:0]  line_q, line_d;
  logic [7:0]  blk_q, blk_d;
  logic [11:0] tx_q, tx_d;
  logic        uflow_q, uflow_d;
  logic        pend_q, pend_d;
  logic        frame_done;
  logic        last_line;
  sync_code_e  code_s;

  assign last_line = (line_q == LAST_LINE);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge SDR_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      blk_q   <= '0;
      tx_q    <= IDLE_WORD;
      uflow_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      blk_q   <= blk_d;
      tx_q    <= tx_d;
      uflow_q <= uflow_d;
      pend_q  <= pend_d;
    end
  end

  // Next state, counters and the word to launch on the next edge.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    pix_d      = pix_q;
    line_d     = line_q;
    blk_d      = blk_q;
    tx_d       = IDLE_WORD;
    uflow_d    = uflow_q;
    pend_d     = pend_q;
    frame_done = 1'b0;
    code_s     = CODE_SOF;

    // A start request during a frame is remembered once; extra pulses merge.
    if (state_q != ST_IDLE && Frame_start) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        line_d = '0;
        pix_d  = '0;
        widx_d = '0;
        if (Frame_start || pend_q) begin
          state_d = ST_SYNC_S;
          uflow_d = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_SYNC_S: begin
        code_s = (line_q == '0) ? CODE_SOF : CODE_SOL;
        tx_d   = sync_word(code_s, widx_q);
        pix_d  = '0;
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd3) state_d = ST_PIXEL;
      end
      ST_PIXEL: begin
        // Slot length is fixed: a missing pixel is filled, never stretched.
        if (Pix_valid) begin
          tx_d = Pix_data;
        end else begin
          tx_d    = UFLOW_WORD;
          uflow_d = 1'b1;
        end
        if (pix_q == LAST_PIX) begin
          pix_d   = '0;
          widx_d  = '0;
          state_d = ST_SYNC_E;
        end else begin
          pix_d = pix_q + 10'd1;
        end
      end
      ST_SYNC_E: begin
        code_s = last_line ? CODE_EOF : CODE_EOL;
        tx_d   = sync_word(code_s, widx_q);
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd3) begin
          blk_d = '0;
          if (last_line) begin
            if (V_BLANK == 0) frame_done = 1'b1;
            else              state_d    = ST_VBLANK;
          end else begin
            line_d  = line_q + 10'd1;
            state_d = (H_BLANK == 0) ? ST_SYNC_S : ST_HBLANK;
          end
        end
      end
      ST_HBLANK: begin
        blk_d = blk_q + 8'd1;
        if (blk_q == H_LAST) begin
          widx_d  = '0;
          state_d = ST_SYNC_S;
        end
      end
      ST_VBLANK: begin
        blk_d = blk_q + 8'd1;
        if (blk_q == V_LAST) frame_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // End of frame: chain straight into a pending (or same-cycle) start.
    if (frame_done) begin
      line_d = '0;
      widx_d = '0;
      pend_d = 1'b0;
      if (pend_q || Frame_start) begin
        state_d = ST_SYNC_S;
        uflow_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign TX_data     = tx_q;
  assign Pix_ready   = (state_q == ST_PIXEL);
  assign Frame_busy  = (state_q != ST_IDLE);
  assign Line_count  = line_q;
  assign Pixel_count = pix_q;
  assign Underflow   = uflow_q;

endmodule
